// File: rtl/serv_alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: operation codes,
// sequencer states and one-hot result-select constants.
package serv_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_BOOL   = 3'd2,
    OP_SLT    = 3'd3,
    OP_SHIFT  = 3'd4,
    OP_BRANCH = 3'd5,
    OP_RSVD6  = 3'd6,
    OP_RSVD7  = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_WAIT = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } seq_state_e;

  localparam logic [3:0] RD_SEL_NONE  = 4'b0000;
  localparam logic [3:0] RD_SEL_ADD   = 4'b0001;
  localparam logic [3:0] RD_SEL_SHIFT = 4'b0010;
  localparam logic [3:0] RD_SEL_SLT   = 4'b0100;
  localparam logic [3:0] RD_SEL_BOOL  = 4'b1000;

  // Shift amount is five bits wide, captured over the first INIT cycles.
  localparam int unsigned SHAMT_CYCLES = 5;

  function automatic logic [3:0] rd_sel_of(input alu_op_e op);
    logic [3:0] sel;
    case (op)
      OP_ADD, OP_SUB: sel = RD_SEL_ADD;
      OP_SHIFT:       sel = RD_SEL_SHIFT;
      OP_SLT:         sel = RD_SEL_SLT;
      OP_BOOL:        sel = RD_SEL_BOOL;
      default:        sel = RD_SEL_NONE;
    endcase
    return sel;
  endfunction

  function automatic logic is_sub_op(input alu_op_e op);
    logic sub;
    case (op)
      OP_SUB, OP_SLT, OP_BRANCH: sub = 1'b1;
      default:                   sub = 1'b0;
    endcase
    return sub;
  endfunction

endpackage

// File: rtl/serv_bit_counter.sv
// Clearable modulo-WIDTH bit counter with first/last-bit flags, shared by
// every serial phase of the sequencer.
module serv_bit_counter #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  output logic [$clog2(WIDTH)-1:0] o_cnt,
  output logic                     o_first,
  output logic                     o_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] r_cnt;

  // Counter wraps naturally since WIDTH is a power of two.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign o_cnt   = r_cnt;
  assign o_first = (r_cnt == '0);
  assign o_last  = (r_cnt == CNT_LAST);

endmodule

// File: rtl/serv_alu_seq.sv
// Bit-serial ALU sequencer: accepts one operation from decode, steps the ALU
// through its serial phases and reports completion and the compare result.
module serv_alu_seq
  import serv_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [2:0] i_op,
  output logic       o_alu_en,
  output logic       o_alu_cnt0,
  output logic       o_alu_cnt_done,
  output logic       o_alu_init,
  output logic       o_alu_shamt_en,
  output logic       o_alu_sub,
  output logic [3:0] o_alu_rd_sel,
  input  logic       i_alu_sh_done,
  input  logic       i_alu_cmp,
  output logic       o_rd_we,
  output logic       o_done,
  output logic       o_cmp_result
);

  localparam int CW = $clog2(WIDTH);

  seq_state_e    r_state;
  seq_state_e    w_next;
  alu_op_e       r_op;
  logic          r_cmp;
  logic          w_accept;
  logic          w_clr;
  logic [CW-1:0] w_cnt;
  logic          w_first;
  logic          w_last;

  assign w_accept = i_valid && (r_state == ST_IDLE);
  // Counter restarts on every state change and idles at zero outside phases.
  assign w_clr    = (w_next != r_state) || (r_state == ST_IDLE) || (r_state == ST_DONE);

  serv_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .o_cnt   (w_cnt),
    .o_first (w_first),
    .o_last  (w_last)
  );

  // State register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operation latch and compare capture
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op  <= OP_ADD;
      r_cmp <= 1'b0;
    end else if (w_accept) begin
      r_op  <= alu_op_e'(i_op);
      r_cmp <= 1'b0;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_cmp <= ((r_op == OP_SLT) || (r_op == OP_BRANCH)) ? i_alu_cmp : 1'b0;
    end else begin
      r_cmp <= r_cmp;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          case (alu_op_e'(i_op))
            OP_SHIFT:                                   w_next = ST_INIT;
            OP_ADD, OP_SUB, OP_BOOL, OP_SLT, OP_BRANCH: w_next = ST_RUN;
            default:                                    w_next = ST_DONE;
          endcase
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_INIT: w_next = w_last ? ST_WAIT : ST_INIT;
      // Counter bounds the wait in case the shifter never reports done.
      ST_WAIT: w_next = (i_alu_sh_done || w_last) ? ST_RUN : ST_WAIT;
      ST_RUN:  w_next = w_last ? ST_DONE : ST_RUN;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Output decode from registered state, counter and latched op
  always_comb begin
    o_ready        = 1'b0;
    o_alu_en       = 1'b0;
    o_alu_cnt0     = 1'b0;
    o_alu_cnt_done = 1'b0;
    o_alu_init     = 1'b0;
    o_alu_shamt_en = 1'b0;
    o_alu_sub      = 1'b0;
    o_alu_rd_sel   = RD_SEL_NONE;
    o_rd_we        = 1'b0;
    o_done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_ready = 1'b1;
      end
      ST_INIT: begin
        o_alu_en       = 1'b1;
        o_alu_init     = 1'b1;
        o_alu_cnt0     = w_first;
        o_alu_cnt_done = w_last;
        o_alu_shamt_en = (w_cnt < CW'(SHAMT_CYCLES));
        o_alu_sub      = is_sub_op(r_op);
        o_alu_rd_sel   = rd_sel_of(r_op);
      end
      ST_WAIT: begin
        o_alu_sub    = is_sub_op(r_op);
        o_alu_rd_sel = rd_sel_of(r_op);
      end
      ST_RUN: begin
        o_alu_en       = 1'b1;
        o_alu_cnt0     = w_first;
        o_alu_cnt_done = w_last;
        o_rd_we        = (r_op != OP_BRANCH);
        o_alu_sub      = is_sub_op(r_op);
        o_alu_rd_sel   = rd_sel_of(r_op);
      end
      ST_DONE: begin
        o_done       = 1'b1;
        o_alu_sub    = is_sub_op(r_op);
        o_alu_rd_sel = rd_sel_of(r_op);
      end
      default: begin
        o_ready = 1'b0;
      end
    endcase
  end

  assign o_cmp_result = r_cmp;

endmodule

// File: tb/tb_serv_alu_seq.sv
// Randomized bench for serv_alu_seq: every cycle of every operation is checked
// against a phase-schedule model derived from operation timing rules.
module tb_serv_alu_seq;

  localparam int W = 32;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [2:0] i_op;
  logic       o_alu_en, o_alu_cnt0, o_alu_cnt_done, o_alu_init, o_alu_shamt_en;
  logic       o_alu_sub;
  logic [3:0] o_alu_rd_sel;
  logic       i_alu_sh_done, i_alu_cmp;
  logic       o_rd_we, o_done, o_cmp_result;

  int   n_checks = 0;
  int   n_errors = 0;
  logic model_cmp = 1'b0;

  always #5 clk = ~clk;

  serv_alu_seq #(.WIDTH(W)) dut (
    .clk            (clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_op           (i_op),
    .o_alu_en       (o_alu_en),
    .o_alu_cnt0     (o_alu_cnt0),
    .o_alu_cnt_done (o_alu_cnt_done),
    .o_alu_init     (o_alu_init),
    .o_alu_shamt_en (o_alu_shamt_en),
    .o_alu_sub      (o_alu_sub),
    .o_alu_rd_sel   (o_alu_rd_sel),
    .i_alu_sh_done  (i_alu_sh_done),
    .i_alu_cmp      (i_alu_cmp),
    .o_rd_we        (o_rd_we),
    .o_done         (o_done),
    .o_cmp_result   (o_cmp_result)
  );

  // Observed outputs: ready,en,cnt0,cnt_done,init,shamt_en,sub,rd_sel[3:0],rd_we,done,cmp
  logic [13:0] w_obs;
  assign w_obs = {o_ready, o_alu_en, o_alu_cnt0, o_alu_cnt_done, o_alu_init,
                  o_alu_shamt_en, o_alu_sub, o_alu_rd_sel, o_rd_we, o_done, o_cmp_result};

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] sel_of(input int op);
    if (op == 0 || op == 1) return 4'b0001;
    if (op == 4) return 4'b0010;
    if (op == 3) return 4'b0100;
    if (op == 2) return 4'b1000;
    return 4'b0000;
  endfunction

  function automatic logic [13:0] idle_vec(input logic cmp);
    return {1'b1, 12'b0, cmp};
  endfunction

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      check_value($sformatf("idle%0d", c), 32'(w_obs), 32'(idle_vec(model_cmp)));
      i_valid = 1'b0;
      i_op = 3'($urandom);
      i_alu_sh_done = 1'b1;
      i_alu_cmp = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // sh_at: WAIT cycle (1-based) on which the shifter reports done; >W means never.
  // cmp_last: forced compare value on the last RUN cycle, negative for random.
  task automatic run_op(input int op, input int sh_at, input int cmp_last, input bit hold_valid);
    int w, run_s, last_k, ii, rr;
    bit is_sh, is_rsv, ph_init, ph_wait, ph_run, ph_done;
    logic [13:0] e;
    is_sh  = (op == 4);
    is_rsv = (op >= 6);
    w      = (sh_at >= 1 && sh_at <= W) ? sh_at : W;
    run_s  = is_sh ? (W + w + 1) : 1;
    last_k = is_rsv ? 1 : (run_s + W);

    check_value($sformatf("op%0d_idle", op), 32'(w_obs), 32'(idle_vec(model_cmp)));
    i_valid = 1'b1;
    i_op = 3'(op);
    i_alu_sh_done = 1'($urandom);
    i_alu_cmp = 1'($urandom);
    @(posedge clk); #1;
    model_cmp = 1'b0;

    for (int k = 1; k <= last_k; k++) begin
      ph_init = is_sh && (k <= W);
      ph_wait = is_sh && (k > W) && (k <= W + w);
      ph_run  = !is_rsv && (k >= run_s) && (k < run_s + W);
      ph_done = (k == last_k);
      ii = k - 1;
      rr = k - run_s;
      e = {1'b0, ph_init || ph_run,
           (ph_init && ii == 0) || (ph_run && rr == 0),
           (ph_init && ii == W - 1) || (ph_run && rr == W - 1),
           ph_init, ph_init && (ii < 5),
           (op == 1 || op == 3 || op == 5), sel_of(op),
           ph_run && (op != 5), ph_done, model_cmp};
      check_value($sformatf("op%0d_k%0d", op, k), 32'(w_obs), 32'(e));

      i_valid = hold_valid ? 1'b1 : 1'($urandom);
      i_op = 3'($urandom);
      i_alu_sh_done = ph_wait ? ((k - W) == sh_at) : 1'($urandom);
      if (ph_run && rr == W - 1 && cmp_last >= 0) i_alu_cmp = 1'(cmp_last);
      else i_alu_cmp = 1'($urandom);
      if (ph_run && rr == W - 1) model_cmp = (op == 3 || op == 5) ? i_alu_cmp : 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_mid_run();
    check_value("rst_idle", 32'(w_obs), 32'(idle_vec(model_cmp)));
    i_valid = 1'b1;
    i_op = 3'd0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_value("rst_pre_run", 32'(o_rd_we), 32'(1));
    i_rst_n = 1'b0;
    #1;
    model_cmp = 1'b0;
    check_value("rst_async", 32'(w_obs), 32'(idle_vec(1'b0)));
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycles(4);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_op = 3'd0;
    i_alu_sh_done = 1'b0;
    i_alu_cmp = 1'b0;
    #2;
    check_value("reset", 32'(w_obs), 32'(idle_vec(1'b0)));
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 1, -1, 1'b0);
    run_op(5, 1, 1, 1'b0);
    check_value("branch_cmp_held", 32'(o_cmp_result), 32'(1));
    run_op(3, 1, 0, 1'b1);
    run_op(4, 3, -1, 1'b0);
    run_op(4, W + 1, -1, 1'b0);
    run_op(7, 1, -1, 1'b1);
    run_op(1, 1, -1, 1'b1);
    run_op(6, 1, -1, 1'b0);
    run_op(2, 1, -1, 1'b0);
    reset_mid_run();

    for (int n = 0; n < 40; n++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(1, W + 3)),
             -1, 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
